// File: rtl/miner_pkg.sv
// Shared widths, FSM state encoding and message packing for the nonce sequencer.
// Vectors are declared descending; value bit W-1 is the header/hash MSB ("bit 0" on the core side).
package miner_pkg;

    localparam int HEADER_W = 608;
    localparam int MSG_W    = 640;
    localparam int HASH_W   = 256;
    localparam int NONCE_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic logic [MSG_W-1:0] make_msg(input logic [HEADER_W-1:0] hdr,
                                                   input logic [NONCE_W-1:0]  nonce);
        return {hdr, nonce};
    endfunction

endpackage

// File: rtl/hash_le_cmp.sv
// Combinational unsigned 256-bit a <= b comparator (MSB-first values).
module hash_le_cmp
    import miner_pkg::*;
(
    input  logic [HASH_W-1:0] a,
    input  logic [HASH_W-1:0] b,
    output logic              le
);

    assign le = (a <= b);

endmodule

// File: rtl/nonce_sequencer.sv
// Job dispatcher for miner_core: sweeps a nonce range, pulses the core once per nonce and
// stops on the first hash that is <= target, on range exhaustion, on core timeout or on abort.
module nonce_sequencer
    import miner_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TCNT_W         = 11
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic                abort,
    input  logic [HEADER_W-1:0] header,
    input  logic [NONCE_W-1:0]  nonce_start,
    input  logic [NONCE_W-1:0]  nonce_end,
    input  logic [HASH_W-1:0]   target,
    output logic                hash_enable,
    output logic [MSG_W-1:0]    message,
    input  logic                finished,
    input  logic [HASH_W-1:0]   hash,
    output logic                busy,
    output logic                found,
    output logic                exhausted,
    output logic                err_timeout,
    output logic [NONCE_W-1:0]  golden_nonce,
    output logic [HASH_W-1:0]   golden_hash
);

    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);

    state_t                state_r, state_s;
    logic [HEADER_W-1:0]   header_q_r, header_q_s;
    logic [NONCE_W-1:0]    nonce_cur_r, nonce_cur_s;
    logic [NONCE_W-1:0]    nonce_end_r, nonce_end_s;
    logic [HASH_W-1:0]     target_q_r, target_q_s;
    logic [HASH_W-1:0]     hash_q_r, hash_q_s;
    logic [TCNT_W-1:0]     tcnt_r, tcnt_s;
    logic                  found_r, found_s;
    logic                  exhausted_r, exhausted_s;
    logic                  err_timeout_r, err_timeout_s;
    logic [NONCE_W-1:0]    golden_nonce_r, golden_nonce_s;
    logic [HASH_W-1:0]     golden_hash_r, golden_hash_s;
    logic                  hash_enable_r, hash_enable_s;
    logic                  busy_r, busy_s;
    logic                  load_s;
    logic                  hit_s;

    hash_le_cmp u_cmp (
        .a  (hash_q_r),
        .b  (target_q_r),
        .le (hit_s)
    );

    assign load_s = start & ~abort & ((state_r == ST_IDLE) | (state_r == ST_DONE));

    // State register
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_s = (nonce_start > nonce_end) ? ST_DONE : ST_ISSUE;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_ISSUE: state_s = ST_ARM;
                // Stale finished from the previous hash must drop before waiting
                ST_ARM: begin
                    if (!finished) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_ARM;
                    end
                end
                ST_WAIT: begin
                    if (finished) begin
                        state_s = ST_CHECK;
                    end else if (tcnt_r == TCNT_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                // End test is equality before increment, so 32'hFFFFFFFF never wraps
                ST_CHECK: begin
                    if (hit_s || (nonce_cur_r == nonce_end_r)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ISSUE;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Output / datapath next values, keyed on the transition being taken
    always_comb begin
        header_q_s     = header_q_r;
        nonce_cur_s    = nonce_cur_r;
        nonce_end_s    = nonce_end_r;
        target_q_s     = target_q_r;
        hash_q_s       = hash_q_r;
        tcnt_s         = tcnt_r;
        found_s        = found_r;
        exhausted_s    = exhausted_r;
        err_timeout_s  = err_timeout_r;
        golden_nonce_s = golden_nonce_r;
        golden_hash_s  = golden_hash_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (load_s) begin
                    header_q_s    = header;
                    nonce_cur_s   = nonce_start;
                    nonce_end_s   = nonce_end;
                    target_q_s    = target;
                    found_s       = 1'b0;
                    exhausted_s   = (state_s == ST_DONE);
                    err_timeout_s = 1'b0;
                end else begin
                    found_s = found_r;
                end
            end
            ST_ARM: tcnt_s = {TCNT_W{1'b0}};
            ST_WAIT: begin
                tcnt_s = tcnt_r + TCNT_ONE;
                if (state_s == ST_CHECK) begin
                    hash_q_s = hash;
                end else if (state_s == ST_DONE) begin
                    err_timeout_s = 1'b1;
                end else begin
                    hash_q_s = hash_q_r;
                end
            end
            ST_CHECK: begin
                if (state_s == ST_DONE) begin
                    if (hit_s) begin
                        found_s        = 1'b1;
                        golden_nonce_s = nonce_cur_r;
                        golden_hash_s  = hash_q_r;
                    end else begin
                        exhausted_s = 1'b1;
                    end
                end else if (state_s == ST_ISSUE) begin
                    nonce_cur_s = nonce_cur_r + 32'd1;
                end else begin
                    nonce_cur_s = nonce_cur_r;
                end
            end
            default: tcnt_s = tcnt_r;
        endcase
        hash_enable_s = (state_s == ST_ISSUE);
        busy_s        = (state_s == ST_ISSUE) | (state_s == ST_ARM) |
                        (state_s == ST_WAIT)  | (state_s == ST_CHECK);
    end

    // Datapath and status registers
    always_ff @(posedge clk) begin
        if (n_rst) begin
            header_q_r     <= {HEADER_W{1'b0}};
            nonce_cur_r    <= {NONCE_W{1'b0}};
            nonce_end_r    <= {NONCE_W{1'b0}};
            target_q_r     <= {HASH_W{1'b0}};
            hash_q_r       <= {HASH_W{1'b0}};
            tcnt_r         <= {TCNT_W{1'b0}};
            found_r        <= 1'b0;
            exhausted_r    <= 1'b0;
            err_timeout_r  <= 1'b0;
            golden_nonce_r <= {NONCE_W{1'b0}};
            golden_hash_r  <= {HASH_W{1'b0}};
            hash_enable_r  <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            header_q_r     <= header_q_s;
            nonce_cur_r    <= nonce_cur_s;
            nonce_end_r    <= nonce_end_s;
            target_q_r     <= target_q_s;
            hash_q_r       <= hash_q_s;
            tcnt_r         <= tcnt_s;
            found_r        <= found_s;
            exhausted_r    <= exhausted_s;
            err_timeout_r  <= err_timeout_s;
            golden_nonce_r <= golden_nonce_s;
            golden_hash_r  <= golden_hash_s;
            hash_enable_r  <= hash_enable_s;
            busy_r         <= busy_s;
        end
    end

    assign message      = make_msg(header_q_r, nonce_cur_r);
    assign hash_enable  = hash_enable_r;
    assign busy         = busy_r;
    assign found        = found_r;
    assign exhausted    = exhausted_r;
    assign err_timeout  = err_timeout_r;
    assign golden_nonce = golden_nonce_r;
    assign golden_hash  = golden_hash_r;

endmodule

// File: tb/tb_nonce_sequencer.sv
// Directed bench for nonce_sequencer with a behavioural miner_core (finished 70 cycles after hash_enable).
module tb_nonce_sequencer;

    logic         clk;
    logic         n_rst;
    logic         start;
    logic         abort;
    logic [607:0] header;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic [255:0] target;
    logic         hash_enable;
    logic [639:0] message;
    logic         finished;
    logic [255:0] hash;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic         err_timeout;
    logic [31:0]  golden_nonce;
    logic [255:0] golden_hash;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;
    int zero_cnt = 0;
    int mcnt;
    logic         model_hang;
    logic [639:0] mmsg;

    nonce_sequencer dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .abort        (abort),
        .header       (header),
        .nonce_start  (nonce_start),
        .nonce_end    (nonce_end),
        .target       (target),
        .hash_enable  (hash_enable),
        .message      (message),
        .finished     (finished),
        .hash         (hash),
        .busy         (busy),
        .found        (found),
        .exhausted    (exhausted),
        .err_timeout  (err_timeout),
        .golden_nonce (golden_nonce),
        .golden_hash  (golden_hash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Toy core hash: inverted nonce on top, upper header bits below
    function automatic logic [255:0] model_hash(input logic [639:0] m);
        return {~m[31:0], m[639:416]};
    endfunction

    // Behavioural miner_core
    always @(posedge clk) begin
        if (n_rst) begin
            finished <= 1'b0;
            hash     <= 256'd0;
            mcnt     <= 0;
            mmsg     <= 640'd0;
        end else if (hash_enable) begin
            finished <= 1'b0;
            mcnt     <= 70;
            mmsg     <= message;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1 && !model_hang) begin
                finished <= 1'b1;
                hash     <= model_hash(mmsg);
            end
        end
    end

    // Pulse counter and zero-nonce watch, sampled away from the active edge
    always @(negedge clk) begin
        if (hash_enable) pulses <= pulses + 1;
        if (busy && message[31:0] == 32'd0 && nonce_start == 32'hFFFFFFFE) zero_cnt <= zero_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tg);
        @(negedge clk);
        nonce_start = ns;
        nonce_end   = ne;
        target      = tg;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, {255'd0, busy}, 256'd0);
    endtask

    initial begin
        int p0;
        int z0;
        int n;
        logic [255:0] tgt1;
        n_rst       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        model_hang  = 1'b0;
        header      = {19{32'h9e3779b9}};
        nonce_start = 32'd0;
        nonce_end   = 32'd0;
        target      = 256'd0;
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);

        check_val("rst_busy",  {255'd0, busy}, 256'd0);
        check_val("rst_found", {255'd0, found}, 256'd0);
        check_val("rst_exh",   {255'd0, exhausted}, 256'd0);
        check_val("rst_tmo",   {255'd0, err_timeout}, 256'd0);
        check_val("rst_hen",   {255'd0, hash_enable}, 256'd0);
        check_val("rst_msg",   message[255:0], 256'd0);
        check_val("rst_gn",    {224'd0, golden_nonce}, 256'd0);

        // 1: hit on third nonce
        tgt1 = model_hash({header, 32'h42a14695});
        p0 = pulses;
        pulse_start(32'h42a14693, 32'h42a14697, tgt1);
        wait_idle("t1_done");
        check_val("t1_pulses", 256'(pulses - p0), 256'd3);
        check_val("t1_found",  {255'd0, found}, 256'd1);
        check_val("t1_exh",    {255'd0, exhausted}, 256'd0);
        check_val("t1_gnonce", {224'd0, golden_nonce}, {224'd0, 32'h42a14695});
        check_val("t1_ghash",  golden_hash, tgt1);
        check_val("t1_msg",    {224'd0, message[31:0]}, {224'd0, 32'h42a14695});

        // 2: no hit across a small range
        p0 = pulses;
        pulse_start(32'd0, 32'd2, 256'd0);
        wait_idle("t2_done");
        check_val("t2_pulses", 256'(pulses - p0), 256'd3);
        check_val("t2_exh",    {255'd0, exhausted}, 256'd1);
        check_val("t2_found",  {255'd0, found}, 256'd0);
        check_val("t2_msg",    {224'd0, message[31:0]}, 256'd2);

        // 3: range ending at 32'hFFFFFFFF must not wrap
        p0 = pulses;
        z0 = zero_cnt;
        pulse_start(32'hFFFFFFFE, 32'hFFFFFFFF, 256'd0);
        wait_idle("t3_done");
        check_val("t3_pulses", 256'(pulses - p0), 256'd2);
        check_val("t3_exh",    {255'd0, exhausted}, 256'd1);
        check_val("t3_nowrap", 256'(zero_cnt - z0), 256'd0);
        check_val("t3_msg",    {224'd0, message[31:0]}, {224'd0, 32'hFFFFFFFF});

        // 4: empty range
        p0 = pulses;
        pulse_start(32'd10, 32'd5, 256'd0);
        check_val("t4_exh",    {255'd0, exhausted}, 256'd1);
        check_val("t4_busy",   {255'd0, busy}, 256'd0);
        repeat (3) @(negedge clk);
        check_val("t4_pulses", 256'(pulses - p0), 256'd0);

        // 5: core never finishes
        model_hang = 1'b1;
        pulse_start(32'd7, 32'd7, {256{1'b1}});
        check_val("t5_hen", {255'd0, hash_enable}, 256'd1);
        n = 0;
        while (!err_timeout && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val("t5_cycles", 256'(n), 256'd1026);
        check_val("t5_tmo",    {255'd0, err_timeout}, 256'd1);
        check_val("t5_busy",   {255'd0, busy}, 256'd0);
        check_val("t5_found",  {255'd0, found}, 256'd0);
        model_hang = 1'b0;

        // 6: abort mid-WAIT, then a start during busy is ignored
        pulse_start(32'd300, 32'd310, 256'd0);
        repeat (20) @(negedge clk);
        check_val("t6_busy_pre", {255'd0, busy}, 256'd1);
        p0 = pulses;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("t6_abort_busy", {255'd0, busy}, 256'd0);
        check_val("t6_abort_tmo",  {255'd0, err_timeout}, 256'd0);
        check_val("t6_abort_exh",  {255'd0, exhausted}, 256'd0);
        check_val("t6_abort_hen",  256'(pulses - p0), 256'd0);
        p0 = pulses;
        pulse_start(32'd100, 32'd100, {256{1'b1}});
        repeat (5) @(negedge clk);
        pulse_start(32'd200, 32'd200, 256'd0);
        wait_idle("t6_done");
        check_val("t6_found",  {255'd0, found}, 256'd1);
        check_val("t6_gnonce", {224'd0, golden_nonce}, 256'd100);
        check_val("t6_pulses", 256'(pulses - p0), 256'd1);
        check_val("t6_msg",    {224'd0, message[31:0]}, 256'd100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
